// File: rtl/rot_sched_pkg.sv
// Shared op codes, FSM states and direction constants for the rotating pattern sequencer.
package rot_sched_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_STEP = 2'd1,
    OP_RUN  = 2'd2,
    OP_STOP = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/rot_sched_tick.sv
// Programmable prescaler: counts 0..div and emits a one-cycle tick on the div count.
module rot_tick #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Next count and tick; a clear or a disabled prescaler parks the count at 0.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == div) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rot_sched.sv
// Command-driven sequencer for a rotating pattern register with a paced prescaler.
//   state   | meaning
//   IDLE    | waiting for a command, prescaler held at 0
//   STEP    | rotating a fixed number of times, commands refused
//   RUN     | rotating on every tick until a new command arrives
module rot_sched
  import rot_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV_W = 24,
  parameter int CNT_W = 8
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         cmd_valid,
  output logic                                         cmd_ready,
  input  logic [1:0]                                   cmd_op,
  input  logic                                         cmd_dir,
  input  logic [((WIDTH > CNT_W) ? WIDTH : CNT_W)-1:0] cmd_data,
  input  logic [DIV_W-1:0]                             cmd_div,
  output logic [WIDTH-1:0]                             rot,
  output logic                                         busy,
  output logic                                         done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] rot_q, rot_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] div_q, div_d;

  logic             accept;
  logic             tick;
  logic [WIDTH-1:0] rot_next;
  logic [CNT_W-1:0] step_n;

  assign cmd_ready = (state_q != ST_STEP);
  assign accept    = cmd_valid & cmd_ready;
  assign step_n    = cmd_data[CNT_W-1:0];
  assign rot_next  = (dir_q == DIR_RIGHT) ? {rot_q[0], rot_q[WIDTH-1:1]}
                                          : {rot_q[WIDTH-2:0], rot_q[WIDTH-1]};

  // Accepting a command restarts the prescaler so the first rotation lands div+1 cycles later.
  rot_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state_q != ST_IDLE),
    .div   (div_q),
    .tick  (tick)
  );

  // Command decode takes priority over a tick on the same edge, so a preempted RUN drops its tick.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    rot_d   = rot_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    div_d   = div_q;
    if (accept) begin
      dir_d = cmd_dir;
      div_d = cmd_div;
      rem_d = '0;
      case (op_e'(cmd_op))
        OP_LOAD: begin
          rot_d   = cmd_data[WIDTH-1:0];
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        OP_STEP: begin
          if (step_n == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_STEP;
            rem_d   = step_n;
          end
        end
        OP_RUN: begin
          state_d = ST_RUN;
        end
        OP_STOP: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: ;
      endcase
    end else if (tick) begin
      case (state_q)
        ST_STEP: begin
          rot_d = rot_next;
          rem_d = rem_q - 1'b1;
          if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        ST_RUN:  rot_d = rot_next;
        default: ;
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      rot_q   <= {{(WIDTH-1){1'b0}}, 1'b1};
      done_q  <= 1'b0;
      dir_q   <= DIR_LEFT;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      rot_q   <= rot_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      div_q   <= div_d;
    end
  end

  assign rot  = rot_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_rot_sched.sv
// Self-checking bench for rot_sched: directed scenarios plus random command traffic
// compared every cycle against a schedule-based reference model.
module tb_rot_sched;

  localparam int W  = 4;
  localparam int DW = 24;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_data = '0;
  logic [DW-1:0] cmd_div = '0;
  logic [W-1:0]  rot;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  rot_sched #(.WIDTH(W), .DIV_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dir   (cmd_dir),
    .cmd_data  (cmd_data),
    .cmd_div   (cmd_div),
    .rot       (rot),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference model: an operation is described by its accept edge, period and
  // step target; rotations fall on edges start + k*period.
  longint  e;          // index of the next rising edge
  int      m_mode;     // 0 idle, 1 step, 2 run
  longint  m_start;
  longint  m_per;
  int      m_n;
  logic    m_dir;
  logic [W-1:0] m_rot;
  logic    m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic logic [W-1:0] rotate(input logic [W-1:0] r, input logic dir);
    logic [W-1:0] o;
    for (int i = 0; i < W; i++) begin
      if (dir) o[i] = r[(i + 1) % W];
      else     o[(i + 1) % W] = r[i];
    end
    return o;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_start = 0; m_per = 1; m_n = 0; m_dir = 1'b0;
    m_rot = 1; m_done = 1'b0;
  endtask

  task automatic model_edge();
    logic acc;
    acc    = cmd_valid && (m_mode != 1);
    m_done = 1'b0;
    if (acc) begin
      m_start = e;
      m_per   = longint'(cmd_div) + 1;
      m_dir   = cmd_dir;
      case (cmd_op)
        2'd0: begin m_rot = cmd_data[W-1:0]; m_mode = 0; m_done = 1'b1; end
        2'd1: begin
          if (cmd_data == 0) begin m_mode = 0; m_done = 1'b1; end
          else begin m_mode = 1; m_n = int'(cmd_data); end
        end
        2'd2: m_mode = 2;
        default: begin m_mode = 0; m_done = 1'b1; end
      endcase
    end else if (m_mode != 0 && ((e - m_start) % m_per) == 0) begin
      m_rot = rotate(m_rot, m_dir);
      if (m_mode == 1 && ((e - m_start) / m_per) == longint'(m_n)) begin
        m_mode = 0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".rot"},   32'(rot),       32'(m_rot));
    chk({where, ".busy"},  32'(busy),      32'(m_mode != 0));
    chk({where, ".done"},  32'(done),      32'(m_done));
    chk({where, ".ready"}, 32'(cmd_ready), 32'(m_mode != 1));
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    e++;
    #1;
    check_all("cyc");
  endtask

  task automatic send(input logic [1:0] op, input logic dir, input logic [CW-1:0] data,
                      input logic [DW-1:0] div);
    cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_data = data; cmd_div = div;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    e = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state then quiet idle.
    check_all("reset");
    idle(10);
    chk("idle.rot", 32'(rot), 32'h1);

    // STEP 3 left, div 2; a command during STEP is refused.
    send(2'd1, 1'b0, 8'd3, 24'd2);
    idle(4);
    send(2'd0, 1'b0, 8'hF, 24'd0);
    idle(6);
    chk("step3.final", 32'(rot), 32'h8);

    // LOAD 1010 then STEP 1 right div 0.
    send(2'd0, 1'b0, 8'h0A, 24'd0);
    send(2'd1, 1'b1, 8'd1, 24'd0);
    idle(2);
    chk("load_step.rot", 32'(rot), 32'h5);

    // RUN left div 0 from 0001, STOP after 5 cycles.
    send(2'd0, 1'b0, 8'h01, 24'd0);
    send(2'd2, 1'b0, 8'h00, 24'd0);
    idle(5);
    send(2'd3, 1'b0, 8'h00, 24'd0);
    idle(3);

    // STEP 0 and STOP while idle.
    send(2'd1, 1'b0, 8'd0, 24'd5);
    idle(2);
    send(2'd3, 1'b1, 8'd0, 24'd0);
    idle(2);

    // RUN preempted by RUN and by STEP.
    send(2'd2, 1'b1, 8'd0, 24'd1);
    idle(3);
    send(2'd2, 1'b0, 8'd0, 24'd2);
    idle(4);
    send(2'd1, 1'b1, 8'd2, 24'd1);
    idle(6);

    // Longest STEP: remaining counter must not wrap.
    send(2'd0, 1'b0, 8'h03, 24'd0);
    send(2'd1, 1'b0, 8'hFF, 24'd0);
    idle(258);

    // Asynchronous reset in the middle of RUN div 4.
    send(2'd0, 1'b0, 8'h06, 24'd0);
    send(2'd2, 1'b1, 8'd0, 24'd4);
    idle(7);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst_n = 1'b1;
    idle(12);

    // Random command traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [1:0]    op;
        logic [CW-1:0] d;
        op = 2'($urandom_range(0, 3));
        d  = (op == 2'd1) ? CW'($urandom_range(0, 5)) : CW'($urandom);
        send(op, 1'($urandom), d, DW'($urandom_range(0, 3)));
      end else begin
        cyc();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
